// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a valid/ready handshake and a DEPTH-entry skid FIFO.
// Default/Block/Bubble control: Block holds the head, Bubble discards every entry.
module if_id_skid_reg #(
    parameter int unsigned        INST_W     = 32,
    parameter int unsigned        PC_W       = 64,
    parameter int unsigned        DEPTH      = 2,
    parameter logic [INST_W-1:0]  NOP        = 32'h0000_0013,
    parameter logic [PC_W-1:0]    INVALID_PC = '0,
    localparam int unsigned       CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ctrl_signal_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  count,
    output logic              flushed
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_count;
    logic              r_flushed;

    logic              w_default;
    logic              w_bubble;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wp_nxt;
    logic [PTR_W-1:0]  w_rp_nxt;

    // 2'b11 is reserved and behaves as Bubble, so bit 1 alone marks a flush.
    assign w_default = (ctrl_signal_i == 2'b00);
    assign w_bubble  = ctrl_signal_i[1];
    assign w_full    = (r_count == CNT_W'(DEPTH));

    // Ready comes from registered count only; rst gating keeps both low during reset.
    assign in_ready  = rst & w_default & ~w_full;
    assign out_valid = rst & (r_count != '0) & ~w_bubble;

    // Block keeps out_valid up but freezes the FIFO, so only Default may pop.
    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready & w_default;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    assign w_wp_nxt = (r_wp == PTR_W'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    assign w_rp_nxt = (r_rp == PTR_W'(DEPTH - 1)) ? '0 : r_rp + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_flushed <= 1'b0;
        end else if (w_bubble) begin
            r_count   <= '0;
            r_rp      <= r_wp;
            r_flushed <= (r_count != '0) | in_valid;
        end else begin
            r_flushed <= 1'b0;
            if (w_push) begin
                r_wp <= w_wp_nxt;
            end
            if (w_pop) begin
                r_rp <= w_rp_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wp] <= in_inst;
            r_mem_pc[r_wp]   <= in_pc;
        end
    end

    assign out_inst = out_valid ? r_mem_inst[r_rp] : NOP;
    assign out_pc   = out_valid ? r_mem_pc[r_rp]   : INVALID_PC;
    assign count    = r_count;
    assign flushed  = r_flushed;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: DEPTH=2 and DEPTH=1 instances, payloads checked via scoreboards.
module tb_if_id_skid_reg;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [1:0]  ctrl;
    logic        in_valid, in_ready, out_valid, out_ready, flushed;
    logic [31:0] in_inst, out_inst;
    logic [63:0] in_pc, out_pc;
    logic [1:0]  count;

    logic [1:0]  d1_ctrl;
    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_flushed;
    logic [31:0] d1_in_inst, d1_out_inst;
    logic [63:0] d1_in_pc, d1_out_pc;
    logic [0:0]  d1_count;

    int   total;
    int   bad;
    ent_t q0[$];
    ent_t q1[$];
    int   d1_xfers;

    if_id_skid_reg #(.DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .count(count), .flushed(flushed)
    );

    if_id_skid_reg #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .ctrl_signal_i(d1_ctrl),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_inst(d1_in_inst), .in_pc(d1_in_pc),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_inst(d1_out_inst),
        .out_pc(d1_out_pc), .count(d1_count), .flushed(d1_flushed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record accepted pushes, compare transfers against the queue head, then advance one cycle.
    task automatic tick();
        ent_t exp;
        #2;
        if (out_valid && out_ready && ctrl == 2'b00) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL sb0_pop unexpected transfer pc=%h", out_pc);
            end else begin
                exp = q0.pop_front();
                if ({out_inst, out_pc} !== exp) begin
                    bad++;
                    $display("FAIL sb0_data got=%h/%h exp=%h/%h", out_inst, out_pc, exp.inst, exp.pc);
                end
            end
        end
        if (in_valid && in_ready) q0.push_back({in_inst, in_pc});
        if (ctrl[1]) q0.delete();
        if (d1_out_valid && d1_out_ready && d1_ctrl == 2'b00) begin
            total++;
            d1_xfers++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_pop unexpected transfer pc=%h", d1_out_pc);
            end else begin
                exp = q1.pop_front();
                if ({d1_out_inst, d1_out_pc} !== exp) begin
                    bad++;
                    $display("FAIL sb1_data got=%h/%h exp=%h/%h", d1_out_inst, d1_out_pc,
                             exp.inst, exp.pc);
                end
            end
        end
        if (d1_in_valid && d1_in_ready) q1.push_back({d1_in_inst, d1_in_pc});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] c, input logic iv, input logic [31:0] inst,
                         input logic [63:0] pc, input logic ordy);
        ctrl = c; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ctrl = 2'($urandom_range(0, 3)); in_valid = 1'b1; out_ready = 1'($urandom);
            in_inst = $urandom; in_pc = {$urandom, $urandom};
            #3;
            total++;
            if ({out_valid, in_ready, out_inst, out_pc, count, flushed} !==
                {1'b0, 1'b0, 32'h13, 64'h0, 2'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset_state got v=%b r=%b i=%h pc=%h c=%0d f=%b exp 0 0 13 0 0 0",
                         out_valid, in_ready, out_inst, out_pc, count, flushed);
            end
        end
        @(negedge clk);
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, d1_in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=11", {in_ready, d1_in_ready});
        end
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] insts [3] = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, i < 3, (i < 3) ? insts[i] : 32'h0, 64'h1000 + 64'(4 * i), 1'b1);
            #1;
            total++;
            if ({out_valid, in_ready, count} !== {i != 0, 1'b1, (i != 0) ? 2'd1 : 2'd0}) begin
                bad++;
                $display("FAIL stream_c%0d got v=%b r=%b c=%0d exp v=%b r=1 c=%0d", i,
                         out_valid, in_ready, count, i != 0, (i != 0) ? 1 : 0);
            end
            tick();
        end
        drive(2'b00, 1'b0, '0, '0, 1'b1);
        #1;
        total++;
        if ({out_valid, count, out_inst} !== {1'b0, 2'd0, 32'h13}) begin
            bad++;
            $display("FAIL stream_drain got v=%b c=%0d i=%h exp 0 0 13", out_valid, count, out_inst);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 3; r++) begin
            drive(2'b00, 1'b1, 32'h20 + 32'(r), 64'h2000, 1'b0);
            tick();
            drive(2'b00, 1'b1, 32'h30 + 32'(r), 64'h2004, 1'b0);
            #1;
            total++;
            if ({count, in_ready} !== {2'd1, 1'b1}) begin
                bad++;
                $display("FAIL bp_fill r%0d got c=%0d r=%b exp c=1 r=1", r, count, in_ready);
            end
            tick();
            drive(2'b00, 1'b1, 32'hDEAD, 64'h2008, 1'b0);
            #1;
            total++;
            if ({count, in_ready} !== {2'd2, 1'b0}) begin
                bad++;
                $display("FAIL bp_full r%0d got c=%0d r=%b exp c=2 r=0", r, count, in_ready);
            end
            tick();
            drive(2'b00, 1'b0, '0, '0, 1'b1);
            #1;
            total++;
            if ({out_pc, in_ready, count} !== {64'h2000, 1'b0, 2'd2}) begin
                bad++;
                $display("FAIL bp_pop_full r%0d got pc=%h r=%b c=%0d exp 2000 0 2", r, out_pc,
                         in_ready, count);
            end
            tick();
            #1;
            total++;
            if ({out_pc, in_ready, count} !== {64'h2004, 1'b1, 2'd1}) begin
                bad++;
                $display("FAIL bp_pop2 r%0d got pc=%h r=%b c=%0d exp 2004 1 1", r, out_pc,
                         in_ready, count);
            end
            tick();
        end
    endtask

    task automatic test_block();
        drive(2'b00, 1'b1, 32'h33, 64'h3000, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 1'b1, 32'h44, 64'h3004, 1'b1);
            #1;
            total++;
            if ({out_valid, out_pc, out_inst, count, in_ready} !==
                {1'b1, 64'h3000, 32'h33, 2'd1, 1'b0}) begin
                bad++;
                $display("FAIL block_hold c%0d got v=%b pc=%h i=%h c=%0d r=%b exp 1 3000 33 1 0",
                         i, out_valid, out_pc, out_inst, count, in_ready);
            end
            tick();
        end
        drive(2'b00, 1'b0, '0, '0, 1'b1);
        tick();
        #1;
        total++;
        if ({count, out_valid} !== {2'd0, 1'b0}) begin
            bad++;
            $display("FAIL block_release got c=%0d v=%b exp c=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_bubble(input logic [1:0] code);
        drive(2'b00, 1'b1, 32'h51, 64'h5000, 1'b0);
        tick();
        drive(2'b00, 1'b1, 32'h52, 64'h5004, 1'b0);
        tick();
        drive(code, 1'b0, '0, '0, 1'b1);
        #1;
        total++;
        if ({count, out_valid, in_ready, out_inst, out_pc} !==
            {2'd2, 1'b0, 1'b0, 32'h13, 64'h0}) begin
            bad++;
            $display("FAIL bubble%0d_cycle got c=%0d v=%b r=%b i=%h pc=%h exp 2 0 0 13 0",
                     code, count, out_valid, in_ready, out_inst, out_pc);
        end
        tick();
        drive(2'b00, 1'b0, '0, '0, 1'b1);
        #1;
        total++;
        if ({count, flushed, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL bubble%0d_after got c=%0d f=%b v=%b exp 0 1 0", code, count,
                     flushed, out_valid);
        end
        tick();
        drive(2'b00, 1'b1, 32'h40, 64'h4000, 1'b1);
        #1;
        total++;
        if (flushed !== 1'b0) begin
            bad++;
            $display("FAIL bubble%0d_pulse got f=%b exp 0", code, flushed);
        end
        tick();
        drive(2'b00, 1'b0, '0, '0, 1'b1);
        #1;
        total++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 64'h4000, 32'h40}) begin
            bad++;
            $display("FAIL bubble%0d_fresh got v=%b pc=%h i=%h exp 1 4000 40", code,
                     out_valid, out_pc, out_inst);
        end
        tick();
        // Empty FIFO: a push attempt alone flags the flush, an idle bubble does not.
        for (int k = 0; k < 2; k++) begin
            drive(code, k == 0, 32'h66, 64'h6000, 1'b1);
            tick();
            drive(2'b00, 1'b0, '0, '0, 1'b1);
            #1;
            total++;
            if (flushed !== (k == 0)) begin
                bad++;
                $display("FAIL bubble%0d_empty_iv%0d got f=%b exp %b", code, k == 0, flushed,
                         k == 0);
            end
        end
    endtask

    task automatic test_depth1();
        d1_xfers = 0;
        for (int k = 0; k < 6; k++) begin
            d1_ctrl = 2'b00; d1_in_valid = 1'b1; d1_out_ready = 1'b1;
            d1_in_inst = 32'h70 + 32'(k); d1_in_pc = 64'h7000 + 64'(4 * k);
            #1;
            total++;
            if ({d1_count, d1_in_ready, d1_out_valid} !== {k[0], ~k[0], k[0]}) begin
                bad++;
                $display("FAIL d1_toggle c%0d got c=%0d r=%b v=%b exp c=%0d r=%b v=%b", k,
                         d1_count, d1_in_ready, d1_out_valid, k[0], ~k[0], k[0]);
            end
            tick();
        end
        d1_in_valid = 1'b0;
        total++;
        if (d1_xfers != 3) begin
            bad++;
            $display("FAIL d1_throughput got=%0d exp=3", d1_xfers);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(2'b00, 1'b1, 32'h81, 64'h8000, 1'b0);
        tick();
        drive(2'b00, 1'b1, 32'h82, 64'h8004, 1'b0);
        tick();
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        #1 rst = 1'b0;
        #1;
        total++;
        if ({count, out_valid, in_ready, out_pc} !== {2'd0, 1'b0, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL reset_async got c=%0d v=%b r=%b pc=%h exp 0 0 0 0", count,
                     out_valid, in_ready, out_pc);
        end
        q0.delete();
        q1.delete();
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; d1_xfers = 0;
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        d1_ctrl = 2'b00; d1_in_valid = 1'b0; d1_out_ready = 1'b0;
        d1_in_inst = '0; d1_in_pc = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_block();
        test_bubble(2'b10);
        test_bubble(2'b11);
        test_depth1();
        test_reset_mid();
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
